multicycle_ctrl: RTL and testbench

Parametrised multicycle CPU control unit, the successor to the single-width controller. It sequences fetch, decode, execute and data-memory phases for the accumulator datapath (registers A/B/C, IR, PC, ALU, data memory). It generalises opcode and ALU-mode width and adds conditional branches on all comparator flags. It also adds a data-memory ready handshake with timeout, a HALT instruction, and an illegal-opcode fault state.

---
 rtl/multicycle_ctrl_pkg.sv | 49 ++++
 rtl/mem_wait_timer.sv | 34 +++
 rtl/multicycle_ctrl.sv | 179 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle control unit: state encodings,
// opcode offsets relative to the first non-ALU opcode N = 2^MODEW,
// conditional-branch flag indices and the decoded opcode classes.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

  // Opcode offsets above N (opcodes 0..N-1 are ALU operations)
  localparam int unsigned LDA_OFS  = 0;
  localparam int unsigned LDB_OFS  = 1;
  localparam int unsigned STC_OFS  = 2;
  localparam int unsigned JMP_OFS  = 3;
  localparam int unsigned JZA_OFS  = 4;
  localparam int unsigned JZB_OFS  = 5;
  localparam int unsigned JEQ_OFS  = 6;
  localparam int unsigned JGT_OFS  = 7;
  localparam int unsigned JLT_OFS  = 8;
  localparam int unsigned HALT_OFS = 9;
  localparam int unsigned NOP_OFS  = 10;

  // Flag vector bit positions; a Jcc selects bit (offset - JZA_OFS)
  localparam int unsigned FLAG_ZA   = JZA_OFS - JZA_OFS;
  localparam int unsigned FLAG_ZB   = JZB_OFS - JZA_OFS;
  localparam int unsigned FLAG_EQ   = JEQ_OFS - JZA_OFS;
  localparam int unsigned FLAG_GT   = JGT_OFS - JZA_OFS;
  localparam int unsigned FLAG_LT   = JLT_OFS - JZA_OFS;
  localparam int unsigned FLAG_SELW = 3;

  typedef enum logic [3:0] {
    OP_ALU,
    OP_LDA,
    OP_LDB,
    OP_STC,
    OP_JMP,
    OP_JCC,
    OP_HALT,
    OP_NOP,
    OP_ILL
  } op_kind_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts no-ack data-memory wait cycles and flags the last allowed one.
// Ports:
//   clk, rst        clock, async active-high reset
//   i_clear         zero the counter (start of a memory access)
//   i_enable        count one wait cycle (saturating)
//   o_expired_c     counter sits at TIMEOUT-1; never set when TIMEOUT==0
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired_c
);

  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  // Saturating wait counter; clear has priority over count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != CW'(TIMEOUT))) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expired_c = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for the accumulator datapath. Sequences
// FETCH/DECODE/EXEC/MEM, with HALT and illegal-opcode FAULT states that
// hold until reset. Strobes are combinational (Mealy on flags/dm_ack).
// Ports:
//   clk, rst                 clock, async active-high reset
//   en                       run enable, looked at only in FETCH
//   opcode                   instruction opcode from IR
//   za, zb, eq, gt, lt       datapath comparator flags
//   dm_ack                   data memory ready for current access
//   loadA..incPC             register strobes
//   mode                     ALU operation select
//   we_DM, re_DM             data-memory write / read request
//   selA, selB               A/B input mux (1 = data memory)
//   halted, fault            status; state_o exposes the state encoding
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned OPW     = 5,
  parameter int unsigned MODEW   = 3,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [OPW-1:0]   opcode,
  input  logic             za,
  input  logic             zb,
  input  logic             eq,
  input  logic             gt,
  input  logic             lt,
  input  logic             dm_ack,
  output logic             loadA,
  output logic             loadB,
  output logic             loadC,
  output logic             loadIR,
  output logic             loadPC,
  output logic             incPC,
  output logic [MODEW-1:0] mode,
  output logic             we_DM,
  output logic             re_DM,
  output logic             selA,
  output logic             selB,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state_o
);

  localparam int unsigned N = 1 << MODEW;

  state_e                 r_state;
  state_e                 w_next;
  logic [OPW-1:0]         r_op_q;
  op_kind_e               w_kind;
  logic [OPW-1:0]         w_rel;
  logic [FLAG_SELW-1:0]   w_flag_idx;
  logic [7:0]             w_flags;
  logic                   w_flag_sel;
  logic                   w_tmr_clr;
  logic                   w_tmr_en;
  logic                   w_tmr_exp;

  // Map an opcode onto its instruction class
  function automatic op_kind_e classify(input logic [OPW-1:0] op);
    logic [OPW-1:0] rel;
    rel = op - OPW'(N);
    if (op < OPW'(N))                                          return OP_ALU;
    if (rel == OPW'(LDA_OFS))                                  return OP_LDA;
    if (rel == OPW'(LDB_OFS))                                  return OP_LDB;
    if (rel == OPW'(STC_OFS))                                  return OP_STC;
    if (rel == OPW'(JMP_OFS))                                  return OP_JMP;
    if ((rel >= OPW'(JZA_OFS)) && (rel <= OPW'(JLT_OFS)))      return OP_JCC;
    if (rel == OPW'(HALT_OFS))                                 return OP_HALT;
    if (rel == OPW'(NOP_OFS))                                  return OP_NOP;
    return OP_ILL;
  endfunction

  assign w_kind     = classify(r_op_q);
  assign w_rel      = r_op_q - OPW'(N);
  assign w_flag_idx = FLAG_SELW'(w_rel - OPW'(JZA_OFS));
  assign w_flags    = {3'b000, lt, gt, eq, zb, za};
  assign w_flag_sel = w_flags[w_flag_idx];
  assign state_o    = r_state;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_mem_wait_timer (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_tmr_clr),
    .i_enable    (w_tmr_en),
    .o_expired_c (w_tmr_exp)
  );

  // State and latched opcode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op_q  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) r_op_q <= opcode;
    end
  end

  // Next state and strobes
  always_comb begin
    w_next    = r_state;
    w_tmr_clr = 1'b0;
    w_tmr_en  = 1'b0;
    loadA     = 1'b0;
    loadB     = 1'b0;
    loadC     = 1'b0;
    loadIR    = 1'b0;
    loadPC    = 1'b0;
    incPC     = 1'b0;
    mode      = '0;
    we_DM     = 1'b0;
    re_DM     = 1'b0;
    selA      = 1'b0;
    selB      = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;
    case (r_state)
      ST_IDLE: w_next = ST_FETCH;
      ST_FETCH: begin
        if (en) begin
          loadIR = 1'b1;
          incPC  = 1'b1;
          w_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (classify(opcode))
          OP_ALU, OP_JMP, OP_JCC, OP_NOP: w_next = ST_EXEC;
          OP_LDA, OP_LDB, OP_STC: begin
            w_next    = ST_MEM;
            w_tmr_clr = 1'b1;
          end
          OP_HALT: w_next = ST_HALT;
          default: w_next = ST_FAULT;
        endcase
      end
      ST_EXEC: begin
        w_next = ST_FETCH;
        case (w_kind)
          OP_ALU: begin
            loadC = 1'b1;
            mode  = r_op_q[MODEW-1:0];
          end
          OP_JMP:  loadPC = 1'b1;
          OP_JCC:  loadPC = w_flag_sel;
          default: ;
        endcase
      end
      ST_MEM: begin
        re_DM = (w_kind == OP_LDA) || (w_kind == OP_LDB);
        selA  = (w_kind == OP_LDA);
        selB  = (w_kind == OP_LDB);
        we_DM = (w_kind == OP_STC);
        if (dm_ack) begin
          // Ack wins over a coincident timeout
          loadA  = (w_kind == OP_LDA);
          loadB  = (w_kind == OP_LDB);
          w_next = ST_FETCH;
        end else begin
          w_tmr_en = 1'b1;
          if (w_tmr_exp) w_next = ST_FAULT;
        end
      end
      ST_HALT: halted = 1'b1;
      ST_FAULT: begin
        halted = 1'b1;
        fault  = 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with default parameters
// (OPW=5, MODEW=3, TIMEOUT=15).
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [4:0] opcode;
  logic       za, zb, eq, gt, lt;
  logic       dm_ack;
  logic       loadA, loadB, loadC, loadIR, loadPC, incPC;
  logic [2:0] mode;
  logic       we_DM, re_DM, selA, selB, halted, fault;
  logic [2:0] state_o;

  int errors = 0;
  int checks = 0;

  // Strobe vector bit masks
  localparam logic [11:0] S_LA  = 12'h800;
  localparam logic [11:0] S_LB  = 12'h400;
  localparam logic [11:0] S_LC  = 12'h200;
  localparam logic [11:0] S_IR  = 12'h100;
  localparam logic [11:0] S_PC  = 12'h080;
  localparam logic [11:0] S_INC = 12'h040;
  localparam logic [11:0] S_WE  = 12'h020;
  localparam logic [11:0] S_RE  = 12'h010;
  localparam logic [11:0] S_SA  = 12'h008;
  localparam logic [11:0] S_SB  = 12'h004;
  localparam logic [11:0] S_HLT = 12'h002;
  localparam logic [11:0] S_FLT = 12'h001;

  multicycle_ctrl #(.OPW(5), .MODEW(3), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode),
    .za(za), .zb(zb), .eq(eq), .gt(gt), .lt(lt), .dm_ack(dm_ack),
    .loadA(loadA), .loadB(loadB), .loadC(loadC), .loadIR(loadIR),
    .loadPC(loadPC), .incPC(incPC), .mode(mode),
    .we_DM(we_DM), .re_DM(re_DM), .selA(selA), .selB(selB),
    .halted(halted), .fault(fault), .state_o(state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] strobes();
    return {loadA, loadB, loadC, loadIR, loadPC, incPC,
            we_DM, re_DM, selA, selB, halted, fault};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check outputs mid-cycle, then advance past the next rising edge
  task automatic cyc(input string tag, input logic [2:0] st, input logic [11:0] s,
                     input logic [2:0] md);
    @(negedge clk);
    chk({tag, ".state"}, 32'(state_o), 32'(st));
    chk({tag, ".strobes"}, 32'(strobes()), 32'(s));
    chk({tag, ".mode"}, 32'(mode), 32'(md));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // FETCH with en=1 then DECODE; en drops after fetch to show no stall
  task automatic fetch_decode(input string tag, input logic [4:0] op);
    en = 1'b1;
    opcode = op;
    cyc({tag, ".fetch"}, 3'd1, S_IR | S_INC, 3'd0);
    en = 1'b0;
    cyc({tag, ".decode"}, 3'd2, 12'h000, 3'd0);
  endtask

  task automatic set_flags(input logic [4:0] f);
    {lt, gt, eq, zb, za} = f;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; opcode = '0; dm_ack = 1'b0;
    set_flags(5'b0);
    #3;
    chk("reset.state", 32'(state_o), 32'd0);
    chk("reset.strobes", 32'(strobes()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ALU op 5
    cyc("alu5.idle", 3'd0, 12'h000, 3'd0);
    fetch_decode("alu5", 5'd5);
    cyc("alu5.exec", 3'd3, S_LC, 3'd5);
    cyc("alu5.wait0", 3'd1, 12'h000, 3'd0);
    cyc("alu5.wait1", 3'd1, 12'h000, 3'd0);

    // ALU op 3
    fetch_decode("alu3", 5'd3);
    cyc("alu3.exec", 3'd3, S_LC, 3'd3);

    // LDA: two wait cycles then ack
    fetch_decode("lda", 5'd8);
    dm_ack = 1'b0;
    cyc("lda.mem0", 3'd4, S_RE | S_SA, 3'd0);
    cyc("lda.mem1", 3'd4, S_RE | S_SA, 3'd0);
    dm_ack = 1'b1;
    cyc("lda.ack", 3'd4, S_RE | S_SA | S_LA, 3'd0);
    dm_ack = 1'b0;
    cyc("lda.after", 3'd1, 12'h000, 3'd0);

    // LDB: immediate ack
    fetch_decode("ldb", 5'd9);
    dm_ack = 1'b1;
    cyc("ldb.ack", 3'd4, S_RE | S_SB | S_LB, 3'd0);
    dm_ack = 1'b0;

    // JMP with all flags clear
    fetch_decode("jmp", 5'd11);
    set_flags(5'b00000);
    cyc("jmp.exec", 3'd3, S_PC, 3'd0);

    // Conditional branches: selected flag 0 (others 1), then 1 (others 0)
    for (int k = 0; k < 5; k++) begin
      logic [4:0] onehot;
      onehot = 5'(1 << k);
      fetch_decode($sformatf("jcc%0d_f0", 12 + k), 5'(12 + k));
      set_flags(~onehot);
      cyc($sformatf("jcc%0d_f0.exec", 12 + k), 3'd3, 12'h000, 3'd0);
      fetch_decode($sformatf("jcc%0d_f1", 12 + k), 5'(12 + k));
      set_flags(onehot);
      cyc($sformatf("jcc%0d_f1.exec", 12 + k), 3'd3, S_PC, 3'd0);
    end
    set_flags(5'b0);

    // NOP
    fetch_decode("nop", 5'd18);
    cyc("nop.exec", 3'd3, 12'h000, 3'd0);

    // STC with no ack: 15 wait cycles then FAULT
    fetch_decode("stc_to", 5'd10);
    for (int i = 0; i < 15; i++) cyc($sformatf("stc_to.mem%0d", i), 3'd4, S_WE, 3'd0);
    en = 1'b1;
    cyc("stc_to.fault0", 3'd6, S_HLT | S_FLT, 3'd0);
    cyc("stc_to.fault1", 3'd6, S_HLT | S_FLT, 3'd0);
    do_reset();
    en = 1'b0;
    cyc("stc_to.idle", 3'd0, 12'h000, 3'd0);

    // STC with ack in the 15th cycle: goes to FETCH, no fault
    fetch_decode("stc_ack", 5'd10);
    for (int i = 0; i < 14; i++) cyc($sformatf("stc_ack.mem%0d", i), 3'd4, S_WE, 3'd0);
    dm_ack = 1'b1;
    cyc("stc_ack.mem14", 3'd4, S_WE, 3'd0);
    dm_ack = 1'b0;
    cyc("stc_ack.fetch", 3'd1, 12'h000, 3'd0);

    // HALT is absorbing even with en=1
    fetch_decode("halt", 5'd17);
    en = 1'b1;
    cyc("halt.h0", 3'd5, S_HLT, 3'd0);
    cyc("halt.h1", 3'd5, S_HLT, 3'd0);
    cyc("halt.h2", 3'd5, S_HLT, 3'd0);
    do_reset();
    en = 1'b0;
    cyc("halt.idle", 3'd0, 12'h000, 3'd0);

    // Illegal opcode
    fetch_decode("ill", 5'd25);
    cyc("ill.f0", 3'd6, S_HLT | S_FLT, 3'd0);
    cyc("ill.f1", 3'd6, S_HLT | S_FLT, 3'd0);
    do_reset();
    cyc("ill.idle", 3'd0, 12'h000, 3'd0);

    // Reset during MEM drops re_DM before the next edge
    fetch_decode("rstmem", 5'd8);
    dm_ack = 1'b0;
    cyc("rstmem.mem0", 3'd4, S_RE | S_SA, 3'd0);
    chk("rstmem.re_before", 32'(re_DM), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmem.re_async", 32'(re_DM), 32'd0);
    chk("rstmem.state_async", 32'(state_o), 32'd0);
    chk("rstmem.strobes_async", 32'(strobes()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    en = 1'b0;
    cyc("rstmem.idle", 3'd0, 12'h000, 3'd0);
    cyc("rstmem.fetch_wait", 3'd1, 12'h000, 3'd0);
    en = 1'b1;
    cyc("rstmem.fetch", 3'd1, S_IR | S_INC, 3'd0);
    en = 1'b0;
    // DECODE then a NOP proves op_q/counter came back cleanly
    opcode = 5'd18;
    cyc("rstmem.decode", 3'd2, 12'h000, 3'd0);
    cyc("rstmem.nop", 3'd3, 12'h000, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
